// File: rtl/dmem_resp_queue_if.sv
// Data-memory request/response bus between a core-side initiator and the
// fixed-latency response queue.
interface dmem_resp_queue_if;
    logic [31:0] mem_d_addr_i;
    logic [31:0] mem_d_data_wr_i;
    logic        mem_d_rd_i;
    logic [3:0]  mem_d_wr_i;
    logic        mem_d_cacheable_i;
    logic [10:0] mem_d_req_tag_i;
    logic        mem_d_invalidate_i;
    logic        mem_d_writeback_i;
    logic        mem_d_flush_i;
    logic [31:0] mem_d_data_rd_o;
    logic        mem_d_accept_o;
    logic        mem_d_ack_o;
    logic        mem_d_error_o;
    logic [10:0] mem_d_resp_tag_o;

    modport master (
        output mem_d_addr_i, mem_d_data_wr_i, mem_d_rd_i, mem_d_wr_i,
               mem_d_cacheable_i, mem_d_req_tag_i, mem_d_invalidate_i,
               mem_d_writeback_i, mem_d_flush_i,
        input  mem_d_data_rd_o, mem_d_accept_o, mem_d_ack_o,
               mem_d_error_o, mem_d_resp_tag_o
    );

    modport slave (
        input  mem_d_addr_i, mem_d_data_wr_i, mem_d_rd_i, mem_d_wr_i,
               mem_d_cacheable_i, mem_d_req_tag_i, mem_d_invalidate_i,
               mem_d_writeback_i, mem_d_flush_i,
        output mem_d_data_rd_o, mem_d_accept_o, mem_d_ack_o,
               mem_d_error_o, mem_d_resp_tag_o
    );
endinterface

// File: rtl/dmem_resp_queue.sv
// Data memory model: performs the access at accept time, then releases the
// stored responses in order once each entry's latency countdown expires.
module dmem_resp_queue #(
    parameter int          DEPTH     = 4,
    parameter int          LATENCY   = 3,
    parameter int          MEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    dmem_resp_queue_if.slave bus
);
    localparam int               PTR_W     = $clog2(DEPTH);
    localparam int               OCC_W     = $clog2(DEPTH + 1);
    localparam int               WORD_W    = $clog2(MEM_WORDS);
    localparam logic [OCC_W-1:0] DEPTH_C   = OCC_W'(DEPTH);
    localparam logic [32:0]      MEM_BYTES = 33'(MEM_WORDS) * 33'd4;
    // Counter reaches 0 in the cycle the ack register must be loaded.
    localparam logic [3:0]       CNT_LOAD  = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;
    localparam bit               BYPASS_EN = (LATENCY == 1);

    logic [31:0]      r_mem     [MEM_WORDS];
    logic [31:0]      r_q_data  [DEPTH];
    logic [10:0]      r_q_tag   [DEPTH];
    logic [3:0]       r_q_cnt   [DEPTH];
    logic [DEPTH-1:0] r_q_err;
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [OCC_W-1:0] r_occ;
    logic             r_ack;
    logic             r_err;
    logic [31:0]      r_data;
    logic [10:0]      r_tag;

    logic              w_wr_any;
    logic              w_req;
    logic              w_accept;
    logic              w_push;
    logic              w_enq;
    logic              w_pop;
    logic              w_bypass;
    logic              w_queued_any;
    logic [OCC_W-1:0]  w_queued;
    logic [31:0]       w_offset;
    logic              w_in_range;
    logic [WORD_W-1:0] w_idx;
    logic              w_mem_we;
    logic              w_rsp_err;
    logic [31:0]       w_rsp_data;
    logic              w_unused_ok;

    assign w_wr_any = |bus.mem_d_wr_i;
    assign w_req    = bus.mem_d_rd_i | w_wr_any | bus.mem_d_invalidate_i
                    | bus.mem_d_writeback_i | bus.mem_d_flush_i;
    assign w_accept = (r_occ < DEPTH_C) && !rst_i;
    assign w_push   = w_req && w_accept;

    // Occupancy also covers the entry currently presented on the ack register.
    assign w_queued     = r_occ - OCC_W'(r_ack);
    assign w_queued_any = (w_queued != '0);
    assign w_pop        = w_queued_any && (r_q_cnt[r_rptr] == 4'd0);
    assign w_bypass     = BYPASS_EN && w_push && !w_queued_any;
    assign w_enq        = w_push && !w_bypass;

    assign w_offset    = bus.mem_d_addr_i - BASE_ADDR;
    assign w_in_range  = ({1'b0, w_offset} < MEM_BYTES);
    assign w_idx       = w_offset[WORD_W+1:2];
    assign w_unused_ok = ^{bus.mem_d_cacheable_i, w_offset[1:0], w_offset[31:WORD_W+2]};

    always_comb begin
        w_mem_we   = 1'b0;
        w_rsp_err  = 1'b0;
        w_rsp_data = 32'd0;
        if (bus.mem_d_rd_i && w_wr_any) begin
            w_rsp_err = 1'b1;
        end else if (bus.mem_d_rd_i || w_wr_any) begin
            if (!w_in_range) begin
                w_rsp_err = 1'b1;
            end else if (w_wr_any) begin
                w_mem_we = 1'b1;
            end else begin
                w_rsp_data = r_mem[w_idx];
            end
        end
    end

    // Backing store is deliberately outside reset so accepted writes survive it.
    always_ff @(posedge clk_i) begin
        if (w_push && w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_d_wr_i[b]) begin
                    r_mem[w_idx][8*b +: 8] <= bus.mem_d_data_wr_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_enq && (r_wptr == PTR_W'(i))) begin
                r_q_data[i] <= w_rsp_data;
                r_q_err[i]  <= w_rsp_err;
                r_q_tag[i]  <= bus.mem_d_req_tag_i;
                r_q_cnt[i]  <= CNT_LOAD;
            end else if (r_q_cnt[i] != 4'd0) begin
                r_q_cnt[i] <= r_q_cnt[i] - 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
            r_ack  <= 1'b0;
            r_err  <= 1'b0;
            r_data <= 32'd0;
            r_tag  <= 11'd0;
        end else begin
            if (w_enq) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            r_occ <= r_occ + OCC_W'(w_push) - OCC_W'(r_ack);
            r_ack <= w_pop || w_bypass;
            if (w_pop) begin
                r_err  <= r_q_err[r_rptr];
                r_data <= r_q_data[r_rptr];
                r_tag  <= r_q_tag[r_rptr];
            end else if (w_bypass) begin
                r_err  <= w_rsp_err;
                r_data <= w_rsp_data;
                r_tag  <= bus.mem_d_req_tag_i;
            end else begin
                r_err  <= 1'b0;
                r_data <= 32'd0;
                r_tag  <= 11'd0;
            end
        end
    end

    assign bus.mem_d_accept_o   = w_accept;
    assign bus.mem_d_ack_o      = r_ack;
    assign bus.mem_d_error_o    = r_err;
    assign bus.mem_d_data_rd_o  = r_data;
    assign bus.mem_d_resp_tag_o = r_tag;
endmodule

// File: tb/tb_dmem_resp_queue.sv
// Bench for dmem_resp_queue: a default instance for function/timing and a
// long-latency instance that can actually fill its queue.
module tb_dmem_resp_queue;
    localparam int L_A = 3;
    localparam int L_B = 6;

    typedef struct {
        logic [10:0] tag;
        logic        err;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    int   last_wait = 0;
    int   last_a = -100;
    int   last_b = -100;
    exp_t sb_a[$];
    exp_t sb_b[$];
    logic [31:0] mdl_a [1024];
    logic [31:0] mdl_b [1024];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_resp_queue_if bus_a ();
    dmem_resp_queue_if bus_b ();

    dmem_resp_queue #(.DEPTH(4), .LATENCY(L_A), .MEM_WORDS(1024), .BASE_ADDR(32'h8000_0000))
        u_dut (.clk_i(clk), .rst_i(rst), .bus(bus_a));

    dmem_resp_queue #(.DEPTH(4), .LATENCY(L_B), .MEM_WORDS(1024), .BASE_ADDR(32'h8000_0000))
        u_full (.clk_i(clk), .rst_i(rst), .bus(bus_b));

    function automatic void chk(string nm, logic [63:0] obs, logic [63:0] req);
        n_vec++;
        assert (obs === req) else begin
            n_bad++;
            $error("FAIL %s observed=%0h required=%0h", nm, obs, req);
        end
    endfunction

    // Expected response straight from the access rules, plus ack-cycle rule
    // max(accept + LATENCY, previous ack + 1).
    function automatic exp_t model(input bit w, input logic rd, input logic [3:0] wr,
                                   input logic [31:0] addr, input logic [31:0] wd,
                                   input logic [10:0] tag, input int t);
        exp_t        e;
        logic [31:0] off;
        logic [31:0] word;
        logic [9:0]  idx;
        int          lat;
        int          last;
        off    = addr - 32'h8000_0000;
        idx    = off[11:2];
        e.tag  = tag;
        e.err  = 1'b0;
        e.data = 32'd0;
        word   = w ? mdl_b[idx] : mdl_a[idx];
        if (rd && (wr != 4'd0)) begin
            e.err = 1'b1;
        end else if (rd || (wr != 4'd0)) begin
            if (off >= 32'd4096) begin
                e.err = 1'b1;
            end else if (wr != 4'd0) begin
                for (int b = 0; b < 4; b++)
                    if (wr[b]) word[8*b +: 8] = wd[8*b +: 8];
                if (w) mdl_b[idx] = word; else mdl_a[idx] = word;
            end else begin
                e.data = word;
            end
        end
        lat   = w ? L_B : L_A;
        last  = w ? last_b : last_a;
        e.cyc = (t + lat > last + 1) ? t + lat : last + 1;
        if (w) last_b = e.cyc; else last_a = e.cyc;
        return e;
    endfunction

    task automatic drive(input bit w, input logic rd, input logic [3:0] wr, input logic [2:0] mt,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [10:0] tag);
        if (w) begin
            bus_b.mem_d_rd_i = rd;  bus_b.mem_d_wr_i = wr;  bus_b.mem_d_addr_i = addr;
            bus_b.mem_d_data_wr_i = wd;  bus_b.mem_d_req_tag_i = tag;  bus_b.mem_d_cacheable_i = tag[0];
            {bus_b.mem_d_invalidate_i, bus_b.mem_d_writeback_i, bus_b.mem_d_flush_i} = mt;
        end else begin
            bus_a.mem_d_rd_i = rd;  bus_a.mem_d_wr_i = wr;  bus_a.mem_d_addr_i = addr;
            bus_a.mem_d_data_wr_i = wd;  bus_a.mem_d_req_tag_i = tag;  bus_a.mem_d_cacheable_i = tag[0];
            {bus_a.mem_d_invalidate_i, bus_a.mem_d_writeback_i, bus_a.mem_d_flush_i} = mt;
        end
    endtask

    task automatic idle(input bit w);
        drive(w, 1'b0, 4'd0, 3'd0, 32'd0, 32'd0, 11'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds the request until accepted; on accept the expectation is queued.
    task automatic send(input bit w, input logic rd, input logic [3:0] wr, input logic [2:0] mt,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [10:0] tag);
        logic acc;
        int   waited;
        exp_t e;
        acc = 1'b0;
        drive(w, rd, wr, mt, addr, wd, tag);
        for (waited = 0; waited < 40; waited++) begin
            @(negedge clk);
            acc = w ? bus_b.mem_d_accept_o : bus_a.mem_d_accept_o;
            if (acc) break;
            step();
        end
        n_vec++;
        assert (acc) else begin
            n_bad++;
            $error("FAIL send_accept tag=%0h observed accept=0 for %0d cycles, required 1", tag, waited);
        end
        if (acc) begin
            e = model(w, rd, wr, addr, wd, tag, cyc);
            if (w) sb_b.push_back(e); else sb_a.push_back(e);
        end
        last_wait = waited;
        step();
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && (sb_a.size() != 0 || sb_b.size() != 0); i++) step();
        repeat (4) step();
        n_vec++;
        assert (sb_a.size() == 0 && sb_b.size() == 0) else begin
            n_bad++;
            $error("FAIL drain observed pending=%0d/%0d, required 0/0", sb_a.size(), sb_b.size());
        end
    endtask

    always @(negedge clk) begin : mon_a
        exp_t e;
        n_vec++;
        if (bus_a.mem_d_ack_o) begin
            assert (sb_a.size() != 0) else begin
                n_bad++;
                $error("FAIL a_ack_unexpected observed tag=%0h, required no ack", bus_a.mem_d_resp_tag_o);
            end
            if (sb_a.size() != 0) begin
                e = sb_a.pop_front();
                n_vec += 2;
                assert ({bus_a.mem_d_resp_tag_o, bus_a.mem_d_error_o, bus_a.mem_d_data_rd_o} === {e.tag, e.err, e.data}) else begin
                    n_bad++;
                    $error("FAIL a_resp observed tag=%0h err=%0b data=%0h, required tag=%0h err=%0b data=%0h",
                           bus_a.mem_d_resp_tag_o, bus_a.mem_d_error_o, bus_a.mem_d_data_rd_o, e.tag, e.err, e.data);
                end
                assert (cyc === e.cyc) else begin
                    n_bad++;
                    $error("FAIL a_ack_cycle tag=%0h observed cycle=%0d, required %0d", e.tag, cyc, e.cyc);
                end
            end
        end else begin
            assert ({bus_a.mem_d_resp_tag_o, bus_a.mem_d_error_o, bus_a.mem_d_data_rd_o} === 44'd0) else begin
                n_bad++;
                $error("FAIL a_idle_outputs observed tag=%0h err=%0b data=%0h, required 0",
                       bus_a.mem_d_resp_tag_o, bus_a.mem_d_error_o, bus_a.mem_d_data_rd_o);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        n_vec++;
        if (bus_b.mem_d_ack_o) begin
            assert (sb_b.size() != 0) else begin
                n_bad++;
                $error("FAIL b_ack_unexpected observed tag=%0h, required no ack", bus_b.mem_d_resp_tag_o);
            end
            if (sb_b.size() != 0) begin
                e = sb_b.pop_front();
                n_vec += 2;
                assert ({bus_b.mem_d_resp_tag_o, bus_b.mem_d_error_o, bus_b.mem_d_data_rd_o} === {e.tag, e.err, e.data}) else begin
                    n_bad++;
                    $error("FAIL b_resp observed tag=%0h err=%0b data=%0h, required tag=%0h err=%0b data=%0h",
                           bus_b.mem_d_resp_tag_o, bus_b.mem_d_error_o, bus_b.mem_d_data_rd_o, e.tag, e.err, e.data);
                end
                assert (cyc === e.cyc) else begin
                    n_bad++;
                    $error("FAIL b_ack_cycle tag=%0h observed cycle=%0d, required %0d", e.tag, cyc, e.cyc);
                end
            end
        end else begin
            assert ({bus_b.mem_d_resp_tag_o, bus_b.mem_d_error_o, bus_b.mem_d_data_rd_o} === 44'd0) else begin
                n_bad++;
                $error("FAIL b_idle_outputs observed tag=%0h err=%0b data=%0h, required 0",
                       bus_b.mem_d_resp_tag_o, bus_b.mem_d_error_o, bus_b.mem_d_data_rd_o);
            end
        end
    end

    initial begin
        int         nacc;
        logic [8:0] exp_acc;
        idle(1'b0);
        idle(1'b1);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_accept_a", {63'd0, bus_a.mem_d_accept_o}, 64'd0);
        chk("rst_accept_b", {63'd0, bus_b.mem_d_accept_o}, 64'd0);
        chk("rst_ack_a", {63'd0, bus_a.mem_d_ack_o}, 64'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("accept_after_rst_a", {63'd0, bus_a.mem_d_accept_o}, 64'd1);
        chk("accept_after_rst_b", {63'd0, bus_b.mem_d_accept_o}, 64'd1);
        step();

        // Write then read back-to-back
        send(1'b0, 1'b0, 4'hF, 3'd0, 32'h8000_0100, 32'hDEAD_BEEF, 11'd5);
        send(1'b0, 1'b1, 4'h0, 3'd0, 32'h8000_0100, 32'd0, 11'd6);
        chk("wr_rd_b2b_wait", 64'(last_wait), 64'd0);
        idle(1'b0);
        drain();

        // Byte lanes
        send(1'b0, 1'b0, 4'hF, 3'd0, 32'h8000_0010, 32'h1122_3344, 11'h10);
        send(1'b0, 1'b0, 4'b0101, 3'd0, 32'h8000_0010, 32'hAABB_CCDD, 11'h11);
        send(1'b0, 1'b1, 4'h0, 3'd0, 32'h8000_0010, 32'd0, 11'h12);
        idle(1'b0);
        drain();

        // Error and maintenance cases, address boundaries
        send(1'b0, 1'b1, 4'h0, 3'd0, 32'h8000_1000, 32'd0, 11'h20);
        send(1'b0, 1'b1, 4'hF, 3'd0, 32'h8000_0010, 32'hFFFF_FFFF, 11'h21);
        send(1'b0, 1'b1, 4'h0, 3'd0, 32'h8000_0010, 32'd0, 11'h22);
        send(1'b0, 1'b0, 4'h0, 3'b001, 32'h8000_0010, 32'd0, 11'h7FF);
        send(1'b0, 1'b0, 4'h0, 3'b110, 32'h8000_0020, 32'd0, 11'h123);
        send(1'b0, 1'b0, 4'hF, 3'd0, 32'h7FFF_FFFC, 32'h5555_5555, 11'h24);
        send(1'b0, 1'b0, 4'hF, 3'd0, 32'h8000_0FFC, 32'h0BAD_F00D, 11'h25);
        send(1'b0, 1'b1, 4'h0, 3'd0, 32'h8000_0FFF, 32'd0, 11'h26);
        idle(1'b0);
        drain();

        // Isolated request on an empty queue
        send(1'b0, 1'b1, 4'h0, 3'd0, 32'h8000_0100, 32'd0, 11'h2A);
        idle(1'b0);
        repeat (5) step();
        drain();

        // Six held reads at LATENCY 3: queue never fills, acks back-to-back
        for (int k = 0; k < 6; k++) begin
            send(1'b0, 1'b1, 4'h0, 3'd0, 32'h8000_0100, 32'd0, 11'(11'h30 + k));
            chk($sformatf("burst_wait_%0d", k), 64'(last_wait), 64'd0);
        end
        idle(1'b0);
        drain();

        // Full queue on the long-latency instance
        send(1'b1, 1'b0, 4'hF, 3'd0, 32'h8000_0040, 32'hCAFE_F00D, 11'h40);
        idle(1'b1);
        drain();
        nacc    = 0;
        exp_acc = 9'b110001111;
        for (int k = 0; k < 9; k++) begin
            if (nacc < 6) drive(1'b1, 1'b1, 4'h0, 3'd0, 32'h8000_0040, 32'd0, 11'(11'h50 + nacc));
            else          idle(1'b1);
            @(negedge clk);
            chk($sformatf("full_accept_%0d", k), {63'd0, bus_b.mem_d_accept_o}, {63'd0, exp_acc[k]});
            if (bus_b.mem_d_accept_o && nacc < 6) begin
                sb_b.push_back(model(1'b1, 1'b1, 4'h0, 32'h8000_0040, 32'd0, 11'(11'h50 + nacc), cyc));
                nacc++;
            end
            step();
        end
        idle(1'b1);
        chk("full_accepted", 64'(nacc), 64'd6);
        drain();

        // Reset one cycle before the first ack discards in-flight reads
        send(1'b0, 1'b1, 4'h0, 3'd0, 32'h8000_0100, 32'd0, 11'h60);
        send(1'b0, 1'b1, 4'h0, 3'd0, 32'h8000_0100, 32'd0, 11'h61);
        drive(1'b0, 1'b1, 4'h0, 3'd0, 32'h8000_0100, 32'd0, 11'h62);
        rst = 1'b1;
        sb_a.delete();
        sb_b.delete();
        last_a = -100;
        last_b = -100;
        @(negedge clk);
        chk("accept_in_rst", {63'd0, bus_a.mem_d_accept_o}, 64'd0);
        step();
        rst = 1'b0;
        idle(1'b0);
        @(negedge clk);
        chk("accept_after_midrst", {63'd0, bus_a.mem_d_accept_o}, 64'd1);
        repeat (8) step();
        send(1'b0, 1'b1, 4'h0, 3'd0, 32'h8000_0100, 32'd0, 11'h63);
        idle(1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
